// File: rtl/nios2_jtag_debug_scan_engine.sv
// Debug scan engine: oversamples the virtual-JTAG TAP into clk and runs the
// capture/shift/update data register, producing per-instruction update strobes.
module nios2_jtag_debug_scan_engine #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACTION_BIT  = DR_WIDTH - 3,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_IR = 2 ** IR_WIDTH,
  localparam int CNT_W  = $clog2(DR_WIDTH + 1) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tck,
  input  logic                       tdi,
  input  logic                       vs_cdr,
  input  logic                       vs_sdr,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [NUM_IR*DR_WIDTH-1:0] capture_data,
  input  logic                       len_err_clr,
  output logic                       tdo,
  output logic [IR_WIDTH-1:0]        ir_q,
  output logic [DR_WIDTH-1:0]        jdo,
  output logic [NUM_IR-1:0]          take_action,
  output logic [NUM_IR-1:0]          take_no_action,
  output logic [CNT_W-1:0]           shift_count,
  output logic                       len_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Level bit positions inside each synchroniser stage
  localparam int L_TCK = 0;
  localparam int L_TDI = 1;
  localparam int L_CDR = 2;
  localparam int L_SDR = 3;
  localparam int L_UDR = 4;
  localparam int L_UIR = 5;

  typedef enum logic [1:0] {IDLE, SCAN, HELD} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0][5:0]          lvl_sync;
  logic [SYNC_STAGES-1:0][IR_WIDTH-1:0] ir_sync;
  logic [5:0]                           lvl_p0;
  logic [IR_WIDTH-1:0]                  ir_p0;
  logic                                 tck_d_p1, udr_d_p1, uir_d_p1;
  logic                                 tck_rise_p1, udr_rise_p1, uir_rise_p1;
  logic [DR_WIDTH-1:0]                  sr;
  state_t                               state;

  // Stage p0: synchronisers for every TAP-side input
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_sync <= '0;
      ir_sync  <= '0;
    end else begin
      lvl_sync <= {lvl_sync[SYNC_STAGES-2:0], {vs_uir, vs_udr, vs_sdr, vs_cdr, tdi, tck}};
      ir_sync  <= {ir_sync[SYNC_STAGES-2:0], ir_in};
    end
  end

  assign lvl_p0 = lvl_sync[SYNC_STAGES-1];
  assign ir_p0  = ir_sync[SYNC_STAGES-1];

  // Stage p1: registered rise pulses for tck, udr and uir
  always_ff @(posedge clk) begin
    if (reset) begin
      tck_d_p1    <= 1'b0;
      udr_d_p1    <= 1'b0;
      uir_d_p1    <= 1'b0;
      tck_rise_p1 <= 1'b0;
      udr_rise_p1 <= 1'b0;
      uir_rise_p1 <= 1'b0;
    end else begin
      tck_d_p1    <= lvl_p0[L_TCK];
      udr_d_p1    <= lvl_p0[L_UDR];
      uir_d_p1    <= lvl_p0[L_UIR];
      tck_rise_p1 <= lvl_p0[L_TCK] & ~tck_d_p1;
      udr_rise_p1 <= lvl_p0[L_UDR] & ~udr_d_p1;
      uir_rise_p1 <= lvl_p0[L_UIR] & ~uir_d_p1;
    end
  end

  // Stage p2: scan register, instruction latch, update strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sr             <= '0;
      jdo            <= '0;
      ir_q           <= '0;
      shift_count    <= '0;
      len_err        <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;

      if (tck_rise_p1) begin
        if (lvl_p0[L_CDR]) begin
          sr          <= capture_data[int'(ir_q)*DR_WIDTH +: DR_WIDTH];
          shift_count <= '0;
          state       <= SCAN;
        end else if (lvl_p0[L_SDR] && state == SCAN) begin
          sr          <= {lvl_p0[L_TDI], sr[DR_WIDTH-1:1]};
          shift_count <= sat_inc(shift_count);
        end
      end

      // The update below still decodes the old ir_q when uir rises alongside it
      if (uir_rise_p1)
        ir_q <= ir_p0;

      if (udr_rise_p1 && state == SCAN) begin
        jdo   <= sr;
        state <= HELD;
        if (sr[ACTION_BIT])
          take_action[ir_q] <= 1'b1;
        else
          take_no_action[ir_q] <= 1'b1;
      end

      if (udr_rise_p1 && state == SCAN && shift_count != CNT_FULL)
        len_err <= 1'b1;
      else if (len_err_clr)
        len_err <= 1'b0;
    end
  end

  assign tdo = sr[0];

endmodule

// File: tb/tb_nios2_jtag_debug_scan_engine.sv
// Directed bench for the debug scan engine: default 2/38 instance plus a
// 3/8 instance with three-stage synchronisers sharing the TAP strobes.
module tb_nios2_jtag_debug_scan_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tck = 1'b0, tdi = 1'b0;
  logic vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, vs_uir = 1'b0;
  logic len_err_clr = 1'b0;

  logic [1:0]   ir_in_a = '0;
  logic [151:0] capture_data_a;
  logic         tdo_a, len_err_a;
  logic [1:0]   ir_q_a;
  logic [37:0]  jdo_a;
  logic [3:0]   take_action_a, take_no_action_a;
  logic [6:0]   shift_count_a;

  logic [2:0]   ir_in_b = '0;
  logic [63:0]  capture_data_b;
  logic         tdo_b, len_err_b;
  logic [2:0]   ir_q_b;
  logic [7:0]   jdo_b;
  logic [7:0]   take_action_b, take_no_action_b;
  logic [4:0]   shift_count_b;

  int checks = 0;
  int errors = 0;

  int act_tot_a = 0, noact_tot_a = 0, act_tot_b = 0, noact_tot_b = 0;
  logic [3:0] act_last_a = '0, noact_last_a = '0;
  logic [7:0] act_last_b = '0, noact_last_b = '0;

  initial begin
    capture_data_a = {38'h00_0000_0001, 38'h00_0000_0000, 38'h2A_AAAA_AAAA, 38'h08_0000_0000};
    capture_data_b = 64'h0000_3C00_0000_0000;
  end

  always #5 clk = ~clk;

  nios2_jtag_debug_scan_engine u_dut_a (
    .clk(clk), .reset(reset), .tck(tck), .tdi(tdi),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in_a), .capture_data(capture_data_a), .len_err_clr(len_err_clr),
    .tdo(tdo_a), .ir_q(ir_q_a), .jdo(jdo_a), .take_action(take_action_a),
    .take_no_action(take_no_action_a), .shift_count(shift_count_a), .len_err(len_err_a)
  );

  nios2_jtag_debug_scan_engine #(
    .IR_WIDTH(3), .DR_WIDTH(8), .SYNC_STAGES(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .tck(tck), .tdi(tdi),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in_b), .capture_data(capture_data_b), .len_err_clr(len_err_clr),
    .tdo(tdo_b), .ir_q(ir_q_b), .jdo(jdo_b), .take_action(take_action_b),
    .take_no_action(take_no_action_b), .shift_count(shift_count_b), .len_err(len_err_b)
  );

  // Pulse monitor: counts every cycle a strobe vector is non-zero
  always @(posedge clk) begin
    #1;
    if (|take_action_a)    begin act_tot_a++;   act_last_a = take_action_a;      end
    if (|take_no_action_a) begin noact_tot_a++; noact_last_a = take_no_action_a; end
    if (|take_action_b)    begin act_tot_b++;   act_last_b = take_action_b;      end
    if (|take_no_action_b) begin noact_tot_b++; noact_last_b = take_no_action_b; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tck_cycle(input logic d);
    tdi = d;
    tck = 1'b1;
    cyc(6);
    tck = 1'b0;
    cyc(6);
  endtask

  task automatic capture();
    vs_cdr = 1'b1;
    cyc(6);
    tck_cycle(1'b0);
    vs_cdr = 1'b0;
    cyc(2);
  endtask

  task automatic set_ir(input logic [1:0] a, input logic [2:0] b);
    ir_in_a = a;
    ir_in_b = b;
    cyc(2);
    vs_uir = 1'b1;
    cyc(8);
    vs_uir = 1'b0;
    cyc(6);
  endtask

  task automatic update();
    vs_udr = 1'b1;
    cyc(8);
    vs_udr = 1'b0;
    cyc(6);
  endtask

  task automatic shift_ones(input int n);
    vs_sdr = 1'b1;
    cyc(6);
    for (int i = 0; i < n; i++) tck_cycle(1'b1);
    vs_sdr = 1'b0;
    cyc(4);
  endtask

  initial begin : stim
    logic [37:0] cap1;
    logic [37:0] w;
    logic [7:0]  capb;
    logic [7:0]  wb;
    int a0, n0, ab0, nb0;
    cap1 = 38'h2A_AAAA_AAAA;
    w    = 38'h05_1234_5678;
    capb = 8'h3C;
    wb   = 8'hC5;

    // Power-on reset
    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("rst_tdo", tdo_a, 0);
    check("rst_jdo", jdo_a, 0);
    check("rst_ir_q", ir_q_a, 0);
    check("rst_shift_count", shift_count_a, 0);
    check("rst_len_err", len_err_a, 0);

    // Update while IDLE must be ignored
    a0 = act_tot_a; n0 = noact_tot_a; ab0 = act_tot_b; nb0 = noact_tot_b;
    update();
    check("idle_no_pulse_a", (act_tot_a - a0) + (noact_tot_a - n0), 0);
    check("idle_no_pulse_b", (act_tot_b - ab0) + (noact_tot_b - nb0), 0);
    check("idle_jdo_a", jdo_a, 0);
    check("idle_jdo_b", jdo_b, 0);

    // Default round trip on ir=1
    set_ir(2'd1, 3'd0);
    check("ir_q_1", ir_q_a, 1);
    capture();
    vs_sdr = 1'b1;
    cyc(6);
    for (int i = 0; i < 38; i++) begin
      check($sformatf("tdo_stream_%0d", i), tdo_a, cap1[i]);
      tck_cycle(1'b1);
    end
    vs_sdr = 1'b0;
    cyc(4);
    check("dflt_shift_count", shift_count_a, 38);
    a0 = act_tot_a; n0 = noact_tot_a;
    update();
    check("dflt_jdo", jdo_a, 38'h3F_FFFF_FFFF);
    check("dflt_act_cycles", act_tot_a - a0, 1);
    check("dflt_act_bits", act_last_a, 4'b0010);
    check("dflt_noact_cycles", noact_tot_a - n0, 0);
    check("dflt_len_err", len_err_a, 0);

    // No-action on ir=3
    set_ir(2'd3, 3'd0);
    capture();
    vs_sdr = 1'b1;
    cyc(6);
    for (int i = 0; i < 38; i++) tck_cycle(w[i]);
    vs_sdr = 1'b0;
    cyc(4);
    a0 = act_tot_a; n0 = noact_tot_a;
    update();
    check("noact_jdo", jdo_a, w);
    check("noact_cycles", noact_tot_a - n0, 1);
    check("noact_bits", noact_last_a, 4'b1000);
    check("noact_act_cycles", act_tot_a - a0, 0);
    check("noact_len_err", len_err_a, 0);

    // Short scan sets len_err
    capture();
    shift_ones(37);
    check("short_shift_count", shift_count_a, 37);
    update();
    check("short_len_err", len_err_a, 1);
    check("short_jdo", jdo_a, 38'h3F_FFFF_FFFE);
    len_err_clr = 1'b1;
    cyc(1);
    len_err_clr = 1'b0;
    cyc(1);
    check("clr_len_err", len_err_a, 0);

    // Clear coinciding with a new short update; also pins update latency
    capture();
    shift_ones(5);
    a0 = act_tot_a;
    vs_udr = 1'b1;
    cyc(3);
    check("lat_pulse_early", take_action_a, 0);
    check("lat_len_err_pre", len_err_a, 0);
    len_err_clr = 1'b1;
    cyc(1);
    len_err_clr = 1'b0;
    check("lat_pulse_on_time", take_action_a, 4'b1000);
    check("set_beats_clr", len_err_a, 1);
    cyc(1);
    check("pulse_one_cycle", take_action_a, 0);
    check("len_err_sticky", len_err_a, 1);
    cyc(6);
    vs_udr = 1'b0;
    cyc(6);
    check("lat_act_cycles", act_tot_a - a0, 1);

    // Capture beats shift on the same tck rise
    capture();
    shift_ones(4);
    vs_cdr = 1'b1;
    vs_sdr = 1'b1;
    cyc(6);
    tck_cycle(1'b0);
    vs_cdr = 1'b0;
    vs_sdr = 1'b0;
    cyc(2);
    check("prio_shift_count", shift_count_a, 0);
    check("prio_tdo", tdo_a, 1);

    // uir and udr together: update decodes the old instruction
    set_ir(2'd0, 3'd0);
    capture();
    ir_in_a = 2'd2;
    cyc(2);
    a0 = act_tot_a;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    cyc(8);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    cyc(6);
    check("uir_udr_cycles", act_tot_a - a0, 1);
    check("uir_udr_bits", act_last_a, 4'b0001);
    check("uir_udr_ir_q", ir_q_a, 2);
    check("uir_udr_jdo", jdo_a, 38'h08_0000_0000);

    // Reset mid-scan
    capture();
    vs_sdr = 1'b1;
    cyc(6);
    for (int i = 0; i < 3; i++) tck_cycle(1'b1);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("mid_rst_jdo", jdo_a, 0);
    check("mid_rst_ir_q", ir_q_a, 0);
    check("mid_rst_shift_count", shift_count_a, 0);
    check("mid_rst_len_err", len_err_a, 0);
    check("mid_rst_tdo", tdo_a, 0);
    cyc(6);
    tck_cycle(1'b1);
    tck_cycle(1'b1);
    vs_sdr = 1'b0;
    cyc(4);
    check("idle_shift_count", shift_count_a, 0);
    check("idle_shift_tdo", tdo_a, 0);
    check("idle_shift_jdo", jdo_a, 0);

    // Narrow instance: 8-bit round trip on ir=5
    set_ir(2'd2, 3'd5);
    check("b_ir_q", ir_q_b, 5);
    capture();
    vs_sdr = 1'b1;
    cyc(6);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b_tdo_%0d", i), tdo_b, capb[i]);
      tck_cycle(wb[i]);
    end
    vs_sdr = 1'b0;
    cyc(4);
    check("b_shift_count", shift_count_b, 8);
    nb0 = noact_tot_b; ab0 = act_tot_b;
    vs_udr = 1'b1;
    cyc(4);
    check("b_pulse_early", take_no_action_b, 0);
    cyc(1);
    check("b_pulse_on_time", take_no_action_b, 8'b0010_0000);
    check("b_jdo", jdo_b, 8'hC5);
    cyc(1);
    check("b_pulse_one_cycle", take_no_action_b, 0);
    cyc(6);
    vs_udr = 1'b0;
    cyc(6);
    check("b_noact_cycles", noact_tot_b - nb0, 1);
    check("b_act_cycles", act_tot_b - ab0, 0);
    check("b_len_err", len_err_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
